// File: rtl/worldmap_port_arbiter_if.sv
// Client and RAM-side signal bundle around the world map RAM port arbiter.
// The arbiter takes the slave view; clients plus the RAM take the master view.
interface worldmap_port_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 2
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;

    logic          bot_req;
    logic [AW-1:0] bot_addr;
    logic          bot_gnt;
    logic [DW-1:0] bot_data;
    logic          bot_valid;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_valid;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [7:0]    vid_miss_cnt;

    modport slave (
        input  vid_req, vid_addr,
        input  bot_req, bot_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_dout,
        output vid_data, vid_valid,
        output bot_gnt, bot_data, bot_valid,
        output cpu_gnt, cpu_rdata, cpu_valid,
        output ram_addr, ram_we, ram_din,
        output vid_miss_cnt
    );

    modport master (
        output vid_req, vid_addr,
        output bot_req, bot_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_dout,
        input  vid_data, vid_valid,
        input  bot_gnt, bot_data, bot_valid,
        input  cpu_gnt, cpu_rdata, cpu_valid,
        input  ram_addr, ram_we, ram_din,
        input  vid_miss_cnt
    );
endinterface

// File: rtl/worldmap_port_arbiter.sv
// Single-port world map RAM arbiter: video has priority, bot and CPU share the rest
// round-robin, and a bounded wait forces a background grant over video when needed.
module worldmap_port_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 2,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input logic                    clk,
    input logic                    resetn,
    worldmap_port_arbiter_if.slave bus
);
    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_BOT  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    logic [WW-1:0] bot_wait;
    logic [WW-1:0] cpu_wait;
    logic          rr_cpu;
    owner_e        tag_pipe [RD_LAT+1];
    logic [7:0]    miss_cnt;
    logic [DW-1:0] vid_data_q;
    logic [DW-1:0] bot_data_q;
    logic [DW-1:0] cpu_data_q;

    logic   bot_forced;
    logic   cpu_forced;
    logic   forced;
    logic   vid_gnt;
    logic   bot_gnt;
    logic   cpu_gnt;
    logic   miss;
    owner_e rd_owner;

    function automatic logic [WW-1:0] wait_next(input logic req, input logic gnt,
                                                input logic [WW-1:0] cnt);
        logic [WW-1:0] nxt;
        nxt = cnt;
        if (!req || gnt)
            nxt = '0;
        else if (cnt != WAIT_MAX)
            nxt = cnt + WW'(1);
        return nxt;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the priority chain so no path leaves it unassigned and no latch is inferred.
        bot_forced = resetn && bus.bot_req && (bot_wait == WAIT_MAX);
        cpu_forced = resetn && bus.cpu_req && (cpu_wait == WAIT_MAX);
        forced     = bot_forced || cpu_forced;
        vid_gnt    = 1'b0;
        bot_gnt    = 1'b0;
        cpu_gnt    = 1'b0;

        if (forced) begin
            if (bot_forced && cpu_forced) begin
                cpu_gnt = rr_cpu;
                bot_gnt = !rr_cpu;
            end else begin
                bot_gnt = bot_forced;
                cpu_gnt = cpu_forced;
            end
        end else if (resetn && bus.vid_req) begin
            vid_gnt = 1'b1;
        end else if (resetn && bus.bot_req && bus.cpu_req) begin
            cpu_gnt = rr_cpu;
            bot_gnt = !rr_cpu;
        end else if (resetn) begin
            bot_gnt = bus.bot_req;
            cpu_gnt = bus.cpu_req;
        end
    end

    // A forced grant taken while video is asking costs video its slot.
    assign miss = forced && bus.vid_req;

    always_comb begin
        rd_owner = OWN_NONE;
        if (vid_gnt)
            rd_owner = OWN_VID;
        else if (bot_gnt)
            rd_owner = OWN_BOT;
        else if (cpu_gnt && !bus.cpu_we)
            rd_owner = OWN_CPU;
    end

    always_comb begin
        bus.ram_addr = bus.vid_addr;
        if (cpu_gnt)
            bus.ram_addr = bus.cpu_addr;
        else if (bot_gnt)
            bus.ram_addr = bus.bot_addr;
    end

    assign bus.ram_we  = cpu_gnt && bus.cpu_we;
    assign bus.ram_din = bus.cpu_wdata;
    assign bus.bot_gnt = bot_gnt;
    assign bus.cpu_gnt = cpu_gnt;

    // NOTE: registered state uses non-blocking assignments only, so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bot_wait <= '0;
            cpu_wait <= '0;
            rr_cpu   <= 1'b0;
            miss_cnt <= '0;
        end else begin
            bot_wait <= wait_next(bus.bot_req, bot_gnt, bot_wait);
            cpu_wait <= wait_next(bus.cpu_req, cpu_gnt, cpu_wait);
            if (bot_gnt)
                rr_cpu <= 1'b1;
            else if (cpu_gnt)
                rr_cpu <= 1'b0;
            if (miss && miss_cnt != 8'hFF)
                miss_cnt <= miss_cnt + 8'd1;
        end
    end

    // NOTE: the owner tags must be reset, unlike a data RAM, because a stale tag would emit a valid for a read discarded by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i <= RD_LAT; i++)
                tag_pipe[i] <= OWN_NONE;
        end else begin
            tag_pipe[0] <= rd_owner;
            for (int i = 1; i <= RD_LAT; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // ram_dout is valid while the tag sits in stage RD_LAT-1; capture it into the owner's register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vid_data_q <= '0;
            bot_data_q <= '0;
            cpu_data_q <= '0;
        end else begin
            case (tag_pipe[RD_LAT-1])
                OWN_VID: vid_data_q <= bus.ram_dout;
                OWN_BOT: bot_data_q <= bus.ram_dout;
                OWN_CPU: cpu_data_q <= bus.ram_dout;
                default: ;
            endcase
        end
    end

    assign bus.vid_valid    = (tag_pipe[RD_LAT] == OWN_VID);
    assign bus.bot_valid    = (tag_pipe[RD_LAT] == OWN_BOT);
    assign bus.cpu_valid    = (tag_pipe[RD_LAT] == OWN_CPU);
    assign bus.vid_data     = vid_data_q;
    assign bus.bot_data     = bot_data_q;
    assign bus.cpu_rdata    = cpu_data_q;
    assign bus.vid_miss_cnt = miss_cnt;
endmodule
